// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type encoding and the sample vote.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for uart_rx: edge counter, three mid-bit samples and the 2-of-3 vote.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_rx,
   input  logic i_active,
   input  logic i_start,
   output logic o_bit_c,
   output logic o_bit_done_c,
   output logic o_sample_ready_c
);

   localparam int unsigned EDGE_W = $clog2(PRESCALE);
   localparam int unsigned SMP_0  = PRESCALE / 2 - 1;
   localparam int unsigned SMP_1  = PRESCALE / 2;
   localparam int unsigned SMP_2  = PRESCALE / 2 + 1;
   localparam int unsigned READY  = (PRESCALE / 2 + 2 < PRESCALE) ? PRESCALE / 2 + 2 : PRESCALE - 1;
   localparam int unsigned LAST   = PRESCALE - 1;

   logic [EDGE_W-1:0] r_edge_cnt;
   logic              r_smp_0;
   logic              r_smp_1;
   logic              r_smp_2;
   logic              w_wrap;
   logic              w_third;

   assign w_wrap = (r_edge_cnt == EDGE_W'(LAST));

   // Outside a frame the counter parks; the start-detect cycle itself is edge 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge_cnt <= '0;
      end else if (!i_active) begin
         r_edge_cnt <= i_start ? EDGE_W'(1) : '0;
      end else if (w_wrap) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smp_0 <= 1'b1;
         r_smp_1 <= 1'b1;
         r_smp_2 <= 1'b1;
      end else if (i_active) begin
         if (r_edge_cnt == EDGE_W'(SMP_0)) r_smp_0 <= i_rx;
         if (r_edge_cnt == EDGE_W'(SMP_1)) r_smp_1 <= i_rx;
         if (r_edge_cnt == EDGE_W'(SMP_2)) r_smp_2 <= i_rx;
      end
   end

   // Forwarding the live line as third sample keeps the vote usable at the wrap when PRESCALE=4.
   assign w_third          = (r_edge_cnt == EDGE_W'(SMP_2)) ? i_rx : r_smp_2;
   assign o_bit_c          = majority3(r_smp_0, r_smp_1, w_third);
   assign o_bit_done_c     = i_active && w_wrap;
   assign o_sample_ready_c = i_active && (r_edge_cnt == EDGE_W'(READY));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit qualification, LSB-first deserialisation, parity and stop checks.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  Busy
);

   localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   uart_state_e           r_state;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic                  r_par_bad;
   logic [DATA_WIDTH-1:0] r_p_data;
   logic                  r_data_valid;
   logic                  r_par_err;
   logic                  r_stp_err;
   logic                  r_busy;

   logic                  w_active;
   logic                  w_start;
   logic                  w_bit;
   logic                  w_bit_done;
   logic                  w_sample_ready;
   logic                  w_par_exp;

   assign w_active  = (r_state != IDLE);
   assign w_start   = (r_state == IDLE) && !RX_IN;
   assign w_par_exp = (^r_shift) ^ (r_par_typ == PAR_ODD);

   uart_rx_sampler #(
      .PRESCALE (PRESCALE)
   ) u_sampler (
      .clk              (CLK),
      .rst_n            (RST),
      .i_rx             (RX_IN),
      .i_active         (w_active),
      .i_start          (w_start),
      .o_bit_c          (w_bit),
      .o_bit_done_c     (w_bit_done),
      .o_sample_ready_c (w_sample_ready)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_en     <= 1'b0;
         r_par_typ    <= PAR_EVEN;
         r_par_bad    <= 1'b0;
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               // Frame options are frozen here so mid-frame changes cannot corrupt the checks.
               if (!RX_IN) begin
                  r_state   <= START;
                  r_busy    <= 1'b1;
                  r_par_en  <= PAR_EN;
                  r_par_typ <= PAR_TYP;
                  r_par_bad <= 1'b0;
                  r_bit_cnt <= '0;
               end
            end
            START: begin
               if (w_sample_ready && w_bit) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_bit_done) begin
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_done) begin
                  r_shift[r_bit_cnt] <= w_bit;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_par_en ? PARITY : STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (w_bit_done) begin
                  r_par_bad <= (w_bit != w_par_exp);
                  r_state   <= STOP;
               end
            end
            STOP: begin
               // Any error suppresses the data update but the frame still ends normally.
               if (w_bit_done) begin
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
                  r_par_err <= r_par_bad;
                  r_stp_err <= !w_bit;
                  if (!r_par_bad && w_bit) begin
                     r_data_valid <= 1'b1;
                     r_p_data     <= r_shift;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign P_DATA     = r_p_data;
   assign DATA_VALID = r_data_valid;
   assign PAR_ERR    = r_par_err;
   assign STP_ERR    = r_stp_err;
   assign Busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomised traffic checked every cycle against a frame-level model.
module tb_uart_rx;

   localparam int DW   = 8;
   localparam int P    = 8;
   localparam int MAXC = 16384;

   logic          clk     = 1'b0;
   logic          RST     = 1'b0;
   logic          RX_IN   = 1'b1;
   logic          PAR_EN  = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          DATA_VALID;
   logic          PAR_ERR;
   logic          STP_ERR;
   logic          Busy;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;

   // Expected outputs per cycle index; P_DATA is tracked as a held value.
   bit          exp_busy [MAXC];
   bit          exp_dv   [MAXC];
   bit          exp_pe   [MAXC];
   bit          exp_se   [MAXC];
   bit [DW-1:0] exp_word [MAXC];
   bit [DW-1:0] exp_pd = '0;

   uart_rx #(
      .DATA_WIDTH (DW),
      .PRESCALE   (P)
   ) dut (
      .CLK        (clk),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         if (!RST) exp_pd = '0;
         else if (exp_dv[cyc]) exp_pd = exp_word[cyc];
         check("busy",       32'(Busy),       32'(exp_busy[cyc]));
         check("data_valid", 32'(DATA_VALID), 32'(exp_dv[cyc]));
         check("par_err",    32'(PAR_ERR),    32'(exp_pe[cyc]));
         check("stp_err",    32'(STP_ERR),    32'(exp_se[cyc]));
         check("p_data",     32'(P_DATA),     32'(exp_pd));
      end
   end

   task automatic clear_future(input int from);
      for (int c = from; c < MAXC; c++) begin
         exp_busy[c] = 1'b0;
         exp_dv[c]   = 1'b0;
         exp_pe[c]   = 1'b0;
         exp_se[c]   = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting this cycle; g_bit/g_pt flip one sample point, abort_at stops driving early.
   task automatic send_frame(input bit [DW-1:0] d, input bit pe, input bit pt, input bit bad_par,
                             input bit bad_stop, input int g_bit, input int g_pt, input int abort_at);
      int        n;
      int        t0;
      int        e;
      int        b;
      int        ph;
      bit        v;
      bit [15:0] bits;
      n  = DW + 2 + int'(pe);
      t0 = cyc;
      PAR_EN  = pe;
      PAR_TYP = pt;
      bits    = '0;
      for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
      if (pe) bits[DW + 1] = (^d) ^ pt ^ bad_par;
      bits[n - 1] = ~bad_stop;
      for (int c = t0 + 1; c < t0 + n * P; c++) exp_busy[c] = 1'b1;
      e = t0 + n * P;
      exp_dv[e]   = !(pe && bad_par) && !bad_stop;
      exp_pe[e]   = pe && bad_par;
      exp_se[e]   = bad_stop;
      exp_word[e] = d;
      for (int k = 0; k < n * P; k++) begin
         if (abort_at >= 0 && k == abort_at) return;
         b  = k / P;
         ph = k % P;
         v  = bits[b];
         if (b == g_bit && ph == P / 2 - 1 + g_pt) v = ~v;
         RX_IN = v;
         if (k > 0 && ph == 0) begin
            PAR_EN  = 1'($urandom);
            PAR_TYP = 1'($urandom);
         end
         @(negedge clk);
      end
   endtask

   // Low pulse of len cycles from this cycle; returns at the first cycle the receiver is idle again.
   task automatic short_start(input int len);
      int t0;
      t0 = cyc;
      for (int c = t0 + 1; c <= t0 + P / 2 + 2; c++) exp_busy[c] = 1'b1;
      for (int k = 0; k < P / 2 + 3; k++) begin
         RX_IN = (k < len) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_pdata", 32'(P_DATA),     32'h0);
      check("rst_dv",    32'(DATA_VALID), 32'h0);
      check("rst_busy",  32'(Busy),       32'h0);
      #2 RST = 1'b1;
      @(negedge clk);
      idle(4);

      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      check("a5_valid", 32'(DATA_VALID), 32'h1);
      check("a5_pdata", 32'(P_DATA),     32'hA5);
      check("a5_perr",  32'(PAR_ERR),    32'h0);
      check("a5_serr",  32'(STP_ERR),    32'h0);
      idle(5);

      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      check("3c_valid", 32'(DATA_VALID), 32'h1);
      check("3c_pdata", 32'(P_DATA),     32'h3C);
      idle(3);

      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0, -1);
      check("3c_perr",      32'(PAR_ERR),    32'h1);
      check("3c_perr_dv",   32'(DATA_VALID), 32'h0);
      check("3c_perr_hold", 32'(P_DATA),     32'h3C);
      idle(3);

      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      check("55_serr",  32'(STP_ERR),    32'h1);
      check("55_dv",    32'(DATA_VALID), 32'h0);
      check("55_hold",  32'(P_DATA),     32'h3C);
      idle(3);

      short_start(2);
      check("glitch_idle", 32'(Busy), 32'h0);
      idle(2);

      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      check("b2b_01", 32'(P_DATA), 32'h01);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      check("b2b_ff_dv", 32'(DATA_VALID), 32'h1);
      check("b2b_ff",    32'(P_DATA),     32'hFF);
      idle(2);

      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, -1);
      check("vote_fix", 32'(P_DATA), 32'h5A);
      idle(2);

      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 4 * P + 3);
      #2 RST = 1'b0;
      RX_IN = 1'b1;
      #1;
      check("arst_pdata", 32'(P_DATA),     32'h0);
      check("arst_dv",    32'(DATA_VALID), 32'h0);
      check("arst_busy",  32'(Busy),       32'h0);
      check("arst_perr",  32'(PAR_ERR),    32'h0);
      check("arst_serr",  32'(STP_ERR),    32'h0);
      clear_future(cyc + 1);
      repeat (3) @(negedge clk);
      #2 RST = 1'b1;
      @(negedge clk);
      idle(3);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      check("post_rst_dv", 32'(DATA_VALID), 32'h1);
      check("post_rst_81", 32'(P_DATA),     32'h81);
      idle(2);

      for (int f = 0; f < 60; f++) begin
         bit [DW-1:0] d;
         bit          pe;
         bit          pt;
         bit          bp;
         bit          bs;
         int          gb;
         int          gp;
         d  = DW'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         bp = ($urandom_range(0, 5) == 0);
         bs = ($urandom_range(0, 7) == 0);
         gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW + 2)) : -1;
         gp = int'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) short_start(int'($urandom_range(1, 4)));
         send_frame(d, pe, pt, bp, bs, gb, gp, -1);
         idle(int'($urandom_range(0, 3)));
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
